// File: rtl/rr_grant_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_select
// Description : Round-robin arbiter with a registered grant/payload stage.
//               A priority pointer selects which requester is scanned first.
//               The one-hot grant and its binary index are combinational.
//               The granted index and payload are registered one cycle later.
//
// Ports       :
//   clk        in   1                    rising-edge clock
//   reset      in   1                    asynchronous active-high reset
//   request    in   NUM_ENTRIES          per-entry request bits
//   update_lru in   1                    allow pointer update on a grant
//   data_in    in   NUM_ENTRIES*WIDTH    payloads, entry i at [i*WIDTH +: WIDTH]
//   grant_oh   out  NUM_ENTRIES          combinational one-hot grant
//   grant_idx  out  IDX_W                combinational binary grant index
//   q_valid    out  1                    a grant happened last cycle
//   q_index    out  IDX_W                registered granted index
//   q_data     out  WIDTH                registered granted payload
//
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_select #(
  parameter int               NUM_ENTRIES        = 4,
  parameter int               WIDTH              = 32,
  parameter int               SWITCH_EVERY_CYCLE = 1,
  parameter logic [WIDTH-1:0] IDLE_VALUE         = '0,
  localparam int              IDX_W              = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_ENTRIES-1:0]       request,
  input  logic                         update_lru,
  input  logic [NUM_ENTRIES*WIDTH-1:0] data_in,
  output logic [NUM_ENTRIES-1:0]       grant_oh,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         q_valid,
  output logic [IDX_W-1:0]             q_index,
  output logic [WIDTH-1:0]             q_data
);

  // One extra bit of headroom so ptr + offset (at most 2*NUM_ENTRIES-2)
  // never overflows before the modulo correction.
  localparam logic [IDX_W:0]   c_num_entries = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(NUM_ENTRIES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [IDX_W-1:0] out_index_q;
  logic [IDX_W-1:0] out_index_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;

  // --------------------------------------------------------------------------
  // Combinational grant path
  // --------------------------------------------------------------------------
  logic [NUM_ENTRIES-1:0] w_grant_oh;
  logic [IDX_W-1:0]       w_grant_idx;
  logic [WIDTH-1:0]       w_sel_data;
  logic                   w_any_grant;
  logic [IDX_W:0]         w_start;
  logic [IDX_W:0]         w_pos;
  logic                   w_found;

  // Rotating scan starting at the pointer. The pointer can only ever hold
  // 0..NUM_ENTRIES-1, but an out-of-range value is folded to 0 so a
  // non-power-of-two arbiter can never lock up.
  always_comb begin
    w_grant_oh = '0;
    w_found    = 1'b0;
    w_pos      = '0;
    w_start    = ({1'b0, ptr_q} < c_num_entries) ? {1'b0, ptr_q} : '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_pos = w_start + (IDX_W+1)'(i);
      if (w_pos >= c_num_entries) begin
        w_pos = w_pos - c_num_entries;
      end
      if (!w_found && request[w_pos[IDX_W-1:0]]) begin
        w_grant_oh[w_pos[IDX_W-1:0]] = 1'b1;
        w_found                      = 1'b1;
      end
    end
  end

  // One-hot to binary and payload selection as AND-OR trees; both collapse
  // to zero when nothing is granted.
  always_comb begin
    w_grant_idx = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_grant_oh[i]) begin
        w_grant_idx = w_grant_idx | IDX_W'(i);
        w_sel_data  = w_sel_data | data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_any_grant = |w_grant_oh;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ptr_d = ptr_q;
    if (update_lru && w_any_grant) begin
      if (SWITCH_EVERY_CYCLE != 0) begin
        // Move priority just past the winner, wrapping explicitly so that
        // non-power-of-two sizes return to 0.
        ptr_d = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + IDX_W'(1);
      end else begin
        // Park priority on the winner so it keeps the grant while it asks.
        ptr_d = w_grant_idx;
      end
    end
  end

  always_comb begin
    out_valid_d = w_any_grant;
    out_index_d = w_any_grant ? w_grant_idx : '0;
    out_data_d  = w_any_grant ? w_sel_data : IDLE_VALUE;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant_oh  = w_grant_oh;
  assign grant_idx = w_grant_idx;
  assign q_valid   = out_valid_q;
  assign q_index   = out_index_q;
  assign q_data    = out_data_q;

endmodule : rr_grant_select
`default_nettype wire

// File: tb/tb_rr_grant_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_select
// Description : Scoreboard bench for rr_grant_select. Two instances share the
//               stimulus: one rotating every grant, one holding the grantee.
//               Expected registered outputs are queued when a cycle is driven
//               and popped after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_select;

  localparam int          N      = 4;
  localparam int          W      = 32;
  localparam logic [31:0] IDLE1  = 32'h0000_0000;
  localparam logic [31:0] IDLE0  = 32'hDEAD_BEEF;

  typedef struct {
    logic        valid;
    logic [1:0]  index;
    logic [31:0] data;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   request;
  logic           update_lru;
  logic [N*W-1:0] data_in;

  logic [N-1:0] g_oh1, g_oh0;
  logic [1:0]   g_idx1, g_idx0;
  logic         qv1, qv0;
  logic [1:0]   qi1, qi0;
  logic [31:0]  qd1, qd0;

  exp_t q1[$];
  exp_t q0[$];
  int   m_ptr1;
  int   m_ptr0;
  int   n_cmp;
  int   n_err;

  rr_grant_select #(
    .NUM_ENTRIES(N), .WIDTH(W), .SWITCH_EVERY_CYCLE(1), .IDLE_VALUE(IDLE1)
  ) u_dut_sw1 (
    .clk(clk), .reset(reset), .request(request), .update_lru(update_lru),
    .data_in(data_in), .grant_oh(g_oh1), .grant_idx(g_idx1),
    .q_valid(qv1), .q_index(qi1), .q_data(qd1)
  );

  rr_grant_select #(
    .NUM_ENTRIES(N), .WIDTH(W), .SWITCH_EVERY_CYCLE(0), .IDLE_VALUE(IDLE0)
  ) u_dut_sw0 (
    .clk(clk), .reset(reset), .request(request), .update_lru(update_lru),
    .data_in(data_in), .grant_oh(g_oh0), .grant_idx(g_idx0),
    .q_valid(qv0), .q_index(qi0), .q_data(qd0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arbiter: first requester at or after ptr, modulo N; -1 if none.
  function automatic int model_grant(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_oh(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic exp_t make_exp(input int g, input logic [31:0] idle);
    exp_t e;
    e.valid = (g >= 0);
    e.index = (g >= 0) ? 2'(g) : 2'd0;
    e.data  = (g >= 0) ? data_in[g*W +: W] : idle;
    return e;
  endfunction

  // Called one time unit after a rising edge: drives a cycle, checks the
  // combinational grant mid-cycle, then checks the registered outputs.
  task automatic run_cycle(input logic [N-1:0] req, input logic upd);
    int   g1, g0;
    exp_t e;
    request    = req;
    update_lru = upd;
    #1;
    g1 = model_grant(req, m_ptr1);
    g0 = model_grant(req, m_ptr0);
    check_eq("grant_oh_sw1",  64'(g_oh1),  64'(exp_oh(g1)));
    check_eq("grant_idx_sw1", 64'(g_idx1), (g1 < 0) ? 64'd0 : 64'(g1));
    check_eq("grant_oh_sw0",  64'(g_oh0),  64'(exp_oh(g0)));
    check_eq("grant_idx_sw0", 64'(g_idx0), (g0 < 0) ? 64'd0 : 64'(g0));
    q1.push_back(make_exp(g1, IDLE1));
    q0.push_back(make_exp(g0, IDLE0));
    if (upd && g1 >= 0) m_ptr1 = (g1 + 1) % N;
    if (upd && g0 >= 0) m_ptr0 = g0;
    @(posedge clk);
    #1;
    e = q1.pop_front();
    check_eq("q_valid_sw1", 64'(qv1), 64'(e.valid));
    check_eq("q_index_sw1", 64'(qi1), 64'(e.index));
    check_eq("q_data_sw1",  64'(qd1), 64'(e.data));
    e = q0.pop_front();
    check_eq("q_valid_sw0", 64'(qv0), 64'(e.valid));
    check_eq("q_index_sw0", 64'(qi0), 64'(e.index));
    check_eq("q_data_sw0",  64'(qd0), 64'(e.data));
  endtask

  // Asserts reset away from the clock edge and checks that the registers
  // clear immediately and the grant reflects a zero pointer.
  task automatic do_reset(input logic [N-1:0] req);
    request = req;
    reset   = 1'b1;
    #1;
    m_ptr1 = 0;
    m_ptr0 = 0;
    check_eq("rst_q_valid_sw1", 64'(qv1), 64'd0);
    check_eq("rst_q_index_sw1", 64'(qi1), 64'd0);
    check_eq("rst_q_data_sw1",  64'(qd1), 64'd0);
    check_eq("rst_q_valid_sw0", 64'(qv0), 64'd0);
    check_eq("rst_q_index_sw0", 64'(qi0), 64'd0);
    check_eq("rst_q_data_sw0",  64'(qd0), 64'd0);
    check_eq("rst_grant_oh_sw1", 64'(g_oh1), 64'(exp_oh(model_grant(req, 0))));
    check_eq("rst_grant_oh_sw0", 64'(g_oh0), 64'(exp_oh(model_grant(req, 0))));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    m_ptr1     = 0;
    m_ptr0     = 0;
    reset      = 1'b1;
    request    = '0;
    update_lru = 1'b0;
    data_in    = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    @(posedge clk);
    #1;

    // Power-on reset state and first grant goes to the lowest requester.
    do_reset(4'b0000);
    run_cycle(4'b1111, 1'b1);

    // Full contention: rotating instance cycles 0,1,2,3,0 from reset.
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) run_cycle(4'b1111, 1'b1);

    // Idle cycle: no grant, idle payload, pointers untouched.
    run_cycle(4'b0000, 1'b1);
    run_cycle(4'b1111, 1'b1);

    // Holding instance keeps entry 1 until it drops, then moves to 2.
    do_reset(4'b0000);
    for (int i = 0; i < 3; i++) run_cycle(4'b0110, 1'b1);
    run_cycle(4'b0100, 1'b1);

    // Pointer frozen when update_lru is low.
    do_reset(4'b0000);
    for (int i = 0; i < 3; i++) run_cycle(4'b1010, 1'b0);

    // Top entry payload, then wrap-around to entry 0.
    do_reset(4'b0000);
    data_in = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    run_cycle(4'b1000, 1'b1);
    run_cycle(4'b1001, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      run_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-operation with the rotating pointer at 2.
    do_reset(4'b0000);
    run_cycle(4'b1111, 1'b1);
    run_cycle(4'b1111, 1'b1);
    do_reset(4'b1111);
    run_cycle(4'b1111, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_grant_select
`default_nettype wire

// File: doc/rr_grant_select.md
RR_GRANT_SELECT -- requirements
Module: rr_grant_select

Interface
REQ-001 Parameter NUM_ENTRIES, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter WIDTH, default 32: payload bits per requester.
REQ-003 Parameter SWITCH_EVERY_CYCLE, default 1: 1 = rotate priority after every grant; 0 = keep the current grantee while it requests.
REQ-004 Parameter IDLE_VALUE, default 0 (WIDTH bits): payload registered when nothing is granted.
REQ-005 Localparam IDX_W = max(1, ceil(log2(NUM_ENTRIES))).
REQ-006 One clock; reset is asynchronous and active-high. Port names are clk and reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 request  input  NUM_ENTRIES  per-entry request bits.
REQ-010 update_lru  input  1  enables the priority update on a grant.
REQ-011 data_in  input  NUM_ENTRIES*WIDTH  concatenated payloads; entry i occupies bits [i*WIDTH +: WIDTH].
REQ-012 grant_oh  output  NUM_ENTRIES  combinational one-hot grant.
REQ-013 grant_idx  output  IDX_W  combinational binary index of grant_oh; 0 when there is no grant.
REQ-014 q_valid  output  1  registered flag: a grant occurred in the previous cycle.
REQ-015 q_index  output  IDX_W  registered index of the granted entry.
REQ-016 q_data  output  WIDTH  registered payload of the granted entry.

Function
REQ-017 State: priority pointer ptr (IDX_W bits). Entry ptr has the highest priority.
REQ-018 Grant rule: scan ptr, ptr+1, ... modulo NUM_ENTRIES, and grant the first requesting entry.
REQ-019 grant_oh has at most one bit set; it is all-zero when request == 0.
REQ-020 grant_oh depends combinationally on request and ptr only, with zero-cycle latency.
REQ-021 grant_idx is the one-hot-to-binary conversion of grant_oh.
REQ-022 Selected payload = data_in slice at grant_idx.
REQ-023 Pointer update, SWITCH_EVERY_CYCLE=1: on a clock edge with update_lru=1 and grant_oh!=0, ptr <= (grant_idx+1) mod NUM_ENTRIES.
REQ-024 Pointer update, SWITCH_EVERY_CYCLE=0: on a clock edge with update_lru=1 and grant_oh!=0, ptr <= grant_idx. The grantee therefore keeps the grant while it requests; when it drops, the scan continues from its successor.
REQ-025 ptr holds its value when update_lru=0 or grant_oh==0.
REQ-026 ptr wrap: from NUM_ENTRIES-1 it advances to 0, including for non-power-of-two NUM_ENTRIES.
REQ-027 Output register, each edge with grant: q_valid<=1, q_index<=grant_idx, q_data<=selected payload.
REQ-028 Output register, each edge without grant: q_valid<=0, q_index<=0, q_data<=IDLE_VALUE.
REQ-029 Output latency is 1 cycle from request to the q_* outputs.
REQ-030 A request that drops in the same cycle as its would-be grant is not granted; request is sampled combinationally, with no memory of past requests.

Reset
REQ-031 While reset=1: ptr=0, q_valid=0, q_index=0, q_data=0.
REQ-032 Reset takes effect asynchronously, including mid-operation. The combinational grant_oh then reflects ptr=0 immediately.
REQ-033 After reset deasserts, the first grant goes to the lowest-indexed requester.

Verification
REQ-034 Reset, then request=4'b1111 for 5 cycles with SWITCH=1 and update_lru=1 -> grant_idx sequence 0,1,2,3,0; q_index follows the same sequence one cycle later, and q_valid=1.
REQ-035 SWITCH=0, request=4'b0110 for 3 cycles, then 4'b0100 -> grants 1,1,1, then 2.
REQ-036 request=0 for one cycle -> grant_oh=0 and grant_idx=0; next cycle q_valid=0, q_index=0, q_data=IDLE_VALUE; ptr unchanged.
REQ-037 update_lru=0, request=4'b1010 for 3 cycles after reset -> grant stays at 1 every cycle.
REQ-038 data_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000} with request=4'b1000 -> q_data=32'hDDDD0003 and q_index=3 after one edge. The next edge with request=4'b1001 grants entry 0 (wrap-around).
REQ-039 Assert reset asynchronously mid-sequence while ptr=2 -> q_* clear immediately, and with request=4'b1111 the grant_oh is 4'b0001.
